axis_ring_slot_alloc: RTL

- Upstream feeder for the AXI-Stream-to-AXI-MM write bridge.
- Accepts ingress packets and assigns each one a fixed-size slot in a host-memory ring.
- Drives the slot base address plus a one-cycle address-valid pulse, then forwards the packet beats to the bridge.
- Tracks the producer index against a host-written consumer index; drops packets when the ring is full and truncates packets longer than one slot.

---
 rtl/axis_ring_slot_alloc_if.sv | 13 +
 rtl/axis_ring_slot_alloc.sv | 88 ++++++++
 2 files changed

// File: rtl/axis_ring_slot_alloc_if.sv
// axis_ring_slot_alloc_if: AXI-Stream bundle used for the ingress and bridge-side streams.
interface axis_ring_slot_alloc_if #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH/8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic tlast;
  logic tvalid;
  logic tready;
  modport master (output tdata, tkeep, tlast, tvalid, input tready);
  modport slave (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/axis_ring_slot_alloc.sv
// axis_ring_slot_alloc: assigns host ring slots to ingress packets, drops on full, truncates long packets.
// Define AXIS_RING_TRUNC_CNT_EN to build the saturating trunc_count; otherwise trunc_count is 0.
module axis_ring_slot_alloc #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int ADDR_WIDTH = 34,
  parameter int SLOT_IDX_WIDTH = 8,
  parameter int SLOT_SIZE_LOG2 = 11
) (
  input  logic clk,
  input  logic rst,
  input  logic cfg_enable,
  input  logic [ADDR_WIDTH-1:0] cfg_ring_base,
  input  logic [SLOT_IDX_WIDTH:0] cons_idx,
  output logic [SLOT_IDX_WIDTH:0] prod_idx,
  axis_ring_slot_alloc_if.slave s_axis,
  axis_ring_slot_alloc_if.master m_axis,
  output logic [ADDR_WIDTH-1:0] axi_base_addr,
  output logic axi_base_addr_valid,
  output logic [31:0] drop_count,
  output logic [31:0] trunc_count
);
  localparam int BEATS_MAX = (1 << SLOT_SIZE_LOG2) / KEEP_WIDTH;
  localparam int BW = BEATS_MAX > 1 ? $clog2(BEATS_MAX) : 1;
  typedef enum logic [2:0] {IDLE, ADDR, FWD, TRIM, DROP} state_t;
  state_t state;
  logic [BW-1:0] beat;
  logic full, accept, last_beat;
  logic [ADDR_WIDTH-1:0] slot_addr;
  always_comb begin
    full = prod_idx[SLOT_IDX_WIDTH] != cons_idx[SLOT_IDX_WIDTH] &&
           prod_idx[SLOT_IDX_WIDTH-1:0] == cons_idx[SLOT_IDX_WIDTH-1:0];
    slot_addr = cfg_ring_base + (ADDR_WIDTH'(prod_idx[SLOT_IDX_WIDTH-1:0]) << SLOT_SIZE_LOG2);
    last_beat = beat == BW'(BEATS_MAX - 1);
    s_axis.tready = state == FWD ? m_axis.tready : (state == TRIM || state == DROP);
    accept = s_axis.tvalid && s_axis.tready;
    m_axis.tvalid = state == FWD && s_axis.tvalid;
    m_axis.tdata = s_axis.tdata;
    m_axis.tkeep = s_axis.tkeep;
    m_axis.tlast = s_axis.tlast || last_beat;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      prod_idx <= '0;
      axi_base_addr <= '0;
      axi_base_addr_valid <= 1'b0;
      drop_count <= '0;
      beat <= '0;
    end else begin
      axi_base_addr_valid <= 1'b0;
      case (state)
        IDLE: if (s_axis.tvalid && cfg_enable) begin
          if (full) begin
            drop_count <= drop_count + {31'd0, drop_count != '1};
            state <= DROP;
          end else begin
            axi_base_addr <= slot_addr;
            axi_base_addr_valid <= 1'b1;
            beat <= '0;
            state <= ADDR;
          end
        end
        ADDR: state <= FWD;
        FWD: if (accept) begin
          beat <= beat + 1'b1;
          // the slot is consumed on real or forced tlast; overflow beats are then discarded in TRIM
          if (s_axis.tlast || last_beat) begin
            prod_idx <= prod_idx + 1'b1;
            state <= s_axis.tlast ? IDLE : TRIM;
          end
        end
        TRIM, DROP: if (accept && s_axis.tlast) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`ifdef AXIS_RING_TRUNC_CNT_EN
  logic trunc;
  assign trunc = state == FWD && accept && last_beat && !s_axis.tlast;
  always_ff @(posedge clk) begin
    if (rst) trunc_count <= '0;
    else if (trunc && trunc_count != '1) trunc_count <= trunc_count + 1'b1;
  end
`else
  assign trunc_count = '0;
`endif
endmodule
